// File: rtl/dot_product_sequencer_if.sv
// Bundle between the dot-product sequencer and its surroundings.
// master = sequencer side: request in, memory and ALU buses out.
interface dot_product_sequencer_if #(
    parameter int AW = 8
);
    logic          start;
    logic [15:0]   len;
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [AW-1:0] b_stride;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic [15:0]   A_bus;
    logic [15:0]   B_bus;
    logic [2:0]    ALU_OP;
    logic [15:0]   C_bus;
    logic          FLAG_Z;

    modport master (
        input  start, len, a_base, b_base, b_stride,
        input  mem_data, C_bus, FLAG_Z,
        output busy, done, result,
        output mem_rd, mem_addr, A_bus, B_bus, ALU_OP
    );

    modport slave (
        output start, len, a_base, b_base, b_stride,
        output mem_data, C_bus, FLAG_Z,
        input  busy, done, result,
        input  mem_rd, mem_addr, A_bus, B_bus, ALU_OP
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// Dot-product control: walks two vectors in data RAM, all math on shared ALU.
// Ports: clk, rst (async high), bus (master): request/busy/done/result,
//        mem_rd/mem_addr/mem_data, A_bus/B_bus/ALU_OP/C_bus/FLAG_Z.
module dot_product_sequencer #(
    parameter int AW = 8
) (
    input logic                    clk,
    input logic                    rst,
    dot_product_sequencer_if.master bus
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ZER = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [2:0] {
        IDLE, INIT, CHK, RDA, RDB, MUL, ACC, DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   ac;
    logic [15:0]   cnt;
    logic [15:0]   t;
    logic [AW-1:0] pa;
    logic [AW-1:0] pb;
    logic [AW-1:0] bs;
    logic [15:0]   res_q;
    logic [AW-1:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = INIT;
            INIT: state_nx = CHK;
            CHK:  state_nx = bus.FLAG_Z ? DONE : RDA;
            RDA:  state_nx = RDB;
            RDB:  state_nx = MUL;
            MUL:  state_nx = ACC;
            ACC:  state_nx = CHK;
            DONE: state_nx = IDLE;
        endcase
    end

    // mem_addr keeps its last value outside the two read states
    always_comb begin
        bus.ALU_OP   = OP_ZER;
        bus.A_bus    = '0;
        bus.B_bus    = '0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = addr_q;
        bus.busy     = (state != IDLE);
        bus.done     = 1'b0;
        bus.result   = res_q;
        unique case (state)
            CHK: begin
                bus.ALU_OP = OP_SUB;
                bus.A_bus  = cnt;
                bus.B_bus  = 16'd1;
            end
            RDA: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pa;
            end
            RDB: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pb;
            end
            MUL: begin
                bus.ALU_OP = OP_MUL;
                bus.A_bus  = t;
                bus.B_bus  = bus.mem_data;
            end
            ACC: begin
                bus.ALU_OP = OP_ADD;
                bus.A_bus  = ac;
                bus.B_bus  = t;
            end
            DONE: begin
                bus.done   = 1'b1;
                bus.result = ac;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac     <= '0;
            cnt    <= '0;
            t      <= '0;
            pa     <= '0;
            pb     <= '0;
            bs     <= '0;
            res_q  <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= bus.mem_addr;
            unique case (state)
                IDLE: if (bus.start) begin
                    cnt <= bus.len;
                    pa  <= bus.a_base;
                    pb  <= bus.b_base;
                    bs  <= bus.b_stride;
                end
                INIT: ac <= bus.C_bus;
                CHK:  if (!bus.FLAG_Z) cnt <= bus.C_bus;
                RDB:  t <= bus.mem_data;
                MUL:  t <= bus.C_bus;
                ACC: begin
                    ac <= bus.C_bus;
                    pa <= pa + AW'(1);
                    pb <= pb + bs;
                end
                DONE: res_q <= ac;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: RAM and ALU models plus a
// dot-product reference computed with plain arithmetic.
module tb_dot_product_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] mem [256];

    dot_product_sequencer_if #(.AW(8)) bus ();

    dot_product_sequencer #(.AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    always_comb begin
        logic [31:0] p;
        p = bus.A_bus * bus.B_bus;
        case (bus.ALU_OP)
            3'd0:    bus.C_bus = bus.A_bus + bus.B_bus;
            3'd1:    bus.C_bus = bus.A_bus - bus.B_bus;
            3'd2:    bus.C_bus = bus.A_bus;
            3'd4:    bus.C_bus = p[15:0];
            3'd5:    bus.C_bus = p[31:16];
            default: bus.C_bus = 16'd0;
        endcase
        if (bus.ALU_OP == 3'd1) bus.FLAG_Z = (bus.A_bus == 16'd0);
        else                    bus.FLAG_Z = (bus.C_bus == 16'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_result"}, bus.result, 0);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_A_bus"}, bus.A_bus, 0);
        chk({tag, "_B_bus"}, bus.B_bus, 0);
        chk({tag, "_ALU_OP"}, bus.ALU_OP, 3);
    endtask

    // want < 0: take the expected result from the reference model
    task automatic run_job(input string tag, input int n, input int ab,
                           input int bb, input int bs, input int want,
                           input int kick, input int abort_at);
        logic [31:0] acc;
        int exp_res;
        int ea[$];
        int ec[$];
        int ra[$];
        int rc[$];
        int dc[$];
        int last;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            int a;
            int b;
            a = (ab + k) & 255;
            b = (bb + k * bs) & 255;
            acc = acc + mem[a] * mem[b];
            ea.push_back(a);
            ec.push_back(3 + 5 * k);
            ea.push_back(b);
            ec.push_back(4 + 5 * k);
        end
        exp_res = (want >= 0) ? want : int'(acc[15:0]);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.len      = 16'(n);
        bus.a_base   = 8'(ab);
        bus.b_base   = 8'(bb);
        bus.b_stride = 8'(bs);
        last = 6 + 5 * n;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk_reset_outs({tag, "_abort"});
                chk({tag, "_abort_ndone"}, dc.size(), 0);
                @(negedge clk);
                chk({tag, "_abort_hold_done"}, bus.done, 0);
                rst = 1'b0;
                bus.start = 1'b0;
                return;
            end
            if (bus.mem_rd) begin
                ra.push_back(int'(bus.mem_addr));
                rc.push_back(c);
            end
            if (bus.done) dc.push_back(c);
            chk({tag, "_busy"}, bus.busy, (c <= 3 + 5 * n));
            if (c == 1) begin
                bus.start    = 1'b0;
                bus.len      = 16'($urandom);
                bus.a_base   = 8'($urandom);
                bus.b_base   = 8'($urandom);
                bus.b_stride = 8'($urandom);
            end
            if (c == kick) begin
                bus.start = 1'b1;
                bus.len   = 16'd1;
            end else if (c == kick + 1) begin
                bus.start = 1'b0;
            end
        end
        chk({tag, "_ndone"}, dc.size(), 1);
        if (dc.size() > 0) chk({tag, "_done_cyc"}, dc[0], 3 + 5 * n);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_nreads"}, ra.size(), ea.size());
        for (int i = 0; i < ea.size() && i < ra.size(); i++) begin
            chk({tag, "_rd_addr"}, ra[i], ea[i]);
            chk({tag, "_rd_cyc"}, rc[i], ec[i]);
        end
    endtask

    task automatic load_basic();
        mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
        mem[8'h20] = 16'd4; mem[8'h21] = 16'd5; mem[8'h22] = 16'd6;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.a_base   = '0;
        bus.b_base   = '0;
        bus.b_stride = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        #1;
        chk_reset_outs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("post_reset");

        load_basic();
        run_job("basic", 3, 8'h10, 8'h20, 1, 32, 0, 0);
        run_job("zero_len", 0, 8'h10, 8'h20, 1, 0, 0, 0);

        mem[8'h00] = 16'd256; mem[8'h01] = 16'd3;
        mem[8'h40] = 16'd256; mem[8'h44] = 16'd7;
        run_job("ovf_stride", 2, 8'h00, 8'h40, 4, 21, 0, 0);

        run_job("ptr_wrap", 2, 8'hFF, 8'h80, 1, -1, 0, 0);

        load_basic();
        run_job("abort", 3, 8'h10, 8'h20, 1, 32, 0, 7);
        run_job("after_abort", 3, 8'h10, 8'h20, 1, 32, 0, 0);
        run_job("start_busy", 3, 8'h10, 8'h20, 1, 32, 5, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            n = int'($urandom_range(0, 6));
            run_job("rand", n, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), -1,
                    int'($urandom_range(1, 3 + 5 * n)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Control block that computes a 16-bit dot product of two vectors held in a synchronous data memory. It performs every arithmetic step by driving the datapath ALU (`A_bus`, `B_bus`, `ALU_OP`) and consuming `C_bus`/`FLAG_Z`, including loop-count tests. It sits between the matrix-multiply top level, which issues one request per output element, and the shared ALU and data RAM.

## Interface

Parameters:
- `AW`, 8: data memory address width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request pulse; sampled only in IDLE.
- `len`, input, 16: element count; captured on accepted `start`.
- `a_base`, input, AW: address of vector A element 0; captured on accepted `start`.
- `b_base`, input, AW: address of vector B element 0; captured on accepted `start`.
- `b_stride`, input, AW: address increment for vector B (A stride is fixed at 1); captured on accepted `start`.
- `busy`, output, 1: high from the cycle after an accepted `start` through the DONE state.
- `done`, output, 1: one-cycle pulse in DONE.
- `result`, output, 16: dot product; valid from DONE until the next accepted `start`.
- `mem_rd`, output, 1: read strobe.
- `mem_addr`, output, AW: read address.
- `mem_data`, input, 16: read data, valid exactly one cycle after `mem_rd`.
- `A_bus`, output, 16: ALU operand A.
- `B_bus`, output, 16: ALU operand B.
- `ALU_OP`, output, 3: ALU operation code. ADD=0, SUB=1, PASS=2, ZER=3, MUL=4, MULM=5.
- `C_bus`, input, 16: ALU result, combinational from `A_bus`/`B_bus`/`ALU_OP`.
- `FLAG_Z`, input, 1: ALU zero flag. On SUB it is 1 when `A_bus`==0, evaluated before the subtraction.

## Operation

Internal registers: `ac` (accumulator), `cnt` (remaining count), `t` (temp), `pa`, `pb` (pointers).

FSM states and actions:
- **IDLE**: `ALU_OP`=ZER, `A_bus`=`B_bus`=0. On `start`=1: capture inputs, `cnt`<=`len`, `pa`<=`a_base`, `pb`<=`b_base`, go to INIT.
- **INIT**: `ALU_OP`=ZER. `ac`<=`C_bus`. Go to CHK.
- **CHK**: `ALU_OP`=SUB, `A_bus`=`cnt`, `B_bus`=1.
  - If `FLAG_Z`=1: go to DONE.
  - Else: `cnt`<=`C_bus`, go to RDA.
- **RDA**: `mem_rd`=1, `mem_addr`=`pa`. Go to RDB.
- **RDB**: `t`<=`mem_data` (the A element). `mem_rd`=1, `mem_addr`=`pb`. Go to MUL.
- **MUL**: `ALU_OP`=MUL, `A_bus`=`t`, `B_bus`=`mem_data` (the B element). `t`<=`C_bus`. Go to ACC.
- **ACC**: `ALU_OP`=ADD, `A_bus`=`ac`, `B_bus`=`t`. `ac`<=`C_bus`. `pa`<=`pa`+1, `pb`<=`pb`+`b_stride`. Go to CHK.
- **DONE**: `done`=1, `result`<=`ac`. Go to IDLE.

Rules:
- Pointer increments use local adders, not the ALU. Pointers wrap modulo 2^AW.
- All ALU arithmetic is truncated to 16 bits: products and sums wrap modulo 2^16.
- In every state not listed above as driving them: `ALU_OP`=ZER, `A_bus`=`B_bus`=0, `mem_rd`=0, `mem_addr` holds its last value.
- `start` is ignored when not in IDLE. `len`, `a_base`, `b_base` and `b_stride` may change freely after capture.
- `len`=0: CHK exits on its first visit; no memory reads occur; `result`=0.

## Timing

- Reset (asynchronous, any state, including mid-operation): state IDLE; `busy`=0, `done`=0, `result`=0, `mem_rd`=0, `mem_addr`=0, `A_bus`=0, `B_bus`=0, `ALU_OP`=3 (ZER); all internal registers 0. No `done` is generated for the aborted request.
- Cycle numbering: the edge that samples `start` in IDLE is cycle 0.
  - INIT at cycle 1.
  - Element k (0-based) occupies cycles 2+5k through 6+5k (CHK, RDA, RDB, MUL, ACC).
  - Final CHK at cycle 2+5N.
  - DONE (`done`=1) at cycle 3+5N.
  - IDLE at cycle 4+5N; a new `start` may be sampled there.
- `busy` is high for cycles 1 through 3+5N inclusive.
- `mem_rd` for the A element is in cycle 3+5k; `mem_rd` for the B element is in cycle 4+5k.

## Test plan

- **Basic product**: A=[1,2,3] at 0x10, B=[4,5,6] at 0x20, `b_stride`=1, `len`=3 -> `result`=32; `done` high only in cycle 18; exactly 6 reads, at 0x10, 0x20, 0x11, 0x21, 0x12, 0x22.
- **Zero length**: `len`=0 -> `done` in cycle 3, `result`=0, `mem_rd` never asserted.
- **Overflow and stride**: A=[256,3] at 0x00; B=[256 at 0x40, 7 at 0x44]; `b_stride`=4, `len`=2 -> `result`=21 (65536 wraps to 0); B reads at 0x40 and 0x44.
- **Pointer wrap**: `a_base`=0xFF, `len`=2 -> A reads at 0xFF then 0x00.
- **Reset mid-operation**: assert `rst` in cycle 7 of a `len`=3 run -> all outputs return to their reset values immediately; no `done`; a fresh `start` with the basic-product vectors gives 32.
- **Start while busy**: pulse `start` with `len`=1 in cycle 5 of the basic-product run -> ignored; `result`=32 at cycle 18; no second `done`.
